// File: rtl/otter_cu_fsm_mc.sv
// ----------------------------------------------------------------------------
// otter_cu_fsm_mc
// Multicycle control FSM for the OTTER RV32I MCU. It sequences instruction
// fetch, execute, load wait/writeback and interrupt entry, and drives the PC,
// register file, memory and CSR enables. Instruction- and data-memory read
// latencies are parameters; read enables are held for that many cycles.
//
// Parameters:
//   IMEM_LAT  instruction-memory read latency in cycles (>=1)
//   DMEM_LAT  data-memory read latency in cycles (>=1)
//
// Ports:
//   CLK, RST             clock; synchronous active-high reset
//   ir_opcode, ir_funct3 instruction fields [6:0] and [14:12]
//   intr, mie            interrupt request (level) and global enable
//   PCWrite, regWrite    PC update / register-file write enables
//   memWE2, memRDEN1/2   data write, instruction read, data read enables
//   reset                PC reset
//   csr_WE               CSR write enable
//   int_taken, mret_exec interrupt-entry and mret strobes
//   state_o              present state (INIT=0 FETCH=1 EXEC=2 LD_WAIT=3
//                        WB=4 INTR=5)
//   illegal_o            only with CU_ILLEGAL_TRAP_EN: undefined opcode in
//                        EXEC (forces interrupt entry next cycle)
//
// Build option: define CU_ILLEGAL_TRAP_EN to trap undefined opcodes.
// ----------------------------------------------------------------------------
module otter_cu_fsm_mc #(
    parameter int unsigned IMEM_LAT = 1,
    parameter int unsigned DMEM_LAT = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] ir_opcode,
    input  logic [2:0] ir_funct3,
    input  logic       intr,
    input  logic       mie,
    output logic       PCWrite,
    output logic       regWrite,
    output logic       memWE2,
    output logic       memRDEN1,
    output logic       memRDEN2,
    output logic       reset,
    output logic       csr_WE,
    output logic       int_taken,
    output logic       mret_exec,
    output logic [2:0] state_o
`ifdef CU_ILLEGAL_TRAP_EN
    ,
    output logic       illegal_o
`endif
);

    localparam int unsigned MAX_LAT = (IMEM_LAT > DMEM_LAT) ? IMEM_LAT : DMEM_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] IMEM_LAST = CNT_W'(IMEM_LAT - 1);
    localparam logic [CNT_W-1:0] DMEM_LAST = CNT_W'(DMEM_LAT - 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_EXEC    = 3'd2,
        ST_LD_WAIT = 3'd3,
        ST_WB      = 3'd4,
        ST_INTR    = 3'd5
    } state_t;

    state_t           ps, ns;
    logic [CNT_W-1:0] lat_cnt, cnt_next;
    logic             irq_req;

    assign irq_req = intr & mie;
    assign state_o = ps;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ps      <= ST_INIT;
            lat_cnt <= '0;
        end else begin
            ps      <= ns;
            lat_cnt <= cnt_next;
        end
    end

    always_comb begin
        ns        = ps;
        cnt_next  = '0;
        PCWrite   = 1'b0;
        regWrite  = 1'b0;
        memWE2    = 1'b0;
        memRDEN1  = 1'b0;
        memRDEN2  = 1'b0;
        reset     = 1'b0;
        csr_WE    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
        illegal_o = 1'b0;
`endif
        case (ps)
            ST_INIT: begin
                reset = 1'b1;
                ns    = ST_FETCH;
            end
            ST_FETCH: begin
                memRDEN1 = 1'b1;
                if (lat_cnt == IMEM_LAST) ns = ST_EXEC;
                else                      cnt_next = lat_cnt + 1'b1;
            end
            ST_EXEC: begin
                if (ir_opcode == OP_LOAD) begin
                    memRDEN2 = 1'b1;
                    if (DMEM_LAT == 1) begin
                        ns = ST_WB;
                    end else begin
                        // EXEC already counts as the first data-read cycle,
                        // so LD_WAIT picks the count up at 1.
                        ns       = ST_LD_WAIT;
                        cnt_next = CNT_W'(1);
                    end
                end else begin
                    PCWrite = 1'b1;
                    ns      = irq_req ? ST_INTR : ST_FETCH;
                    case (ir_opcode)
                        OP_REG, OP_IMM, OP_JALR, OP_JAL, OP_LUI, OP_AUIPC:
                            regWrite = 1'b1;
                        OP_STORE:
                            memWE2 = 1'b1;
                        OP_BRANCH: ;
                        OP_SYSTEM: begin
                            if (ir_funct3 == 3'b000) begin
                                mret_exec = 1'b1;
                            end else if (ir_funct3 != 3'b100) begin
                                csr_WE   = 1'b1;
                                regWrite = 1'b1;
                            end
                        end
                        default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                            illegal_o = 1'b1;
                            ns        = ST_INTR;
`endif
                        end
                    endcase
                end
            end
            ST_LD_WAIT: begin
                memRDEN2 = 1'b1;
                if (lat_cnt == DMEM_LAST) ns = ST_WB;
                else                      cnt_next = lat_cnt + 1'b1;
            end
            ST_WB: begin
                regWrite = 1'b1;
                PCWrite  = 1'b1;
                ns       = irq_req ? ST_INTR : ST_FETCH;
            end
            ST_INTR: begin
                int_taken = 1'b1;
                PCWrite   = 1'b1;
                ns        = ST_FETCH;
            end
            default: ns = ST_INIT;
        endcase
    end

endmodule

// File: tb/tb_otter_cu_fsm_mc.sv
// ----------------------------------------------------------------------------
// tb_otter_cu_fsm_mc
// Two instances run side by side: instance 0 with IMEM_LAT=3/DMEM_LAT=2 and
// instance 1 with IMEM_LAT=1/DMEM_LAT=1. Each has its own driver that issues
// whole instructions; for every cycle the driver queues the outputs the
// instruction must produce in that cycle, and a single negedge process
// compares them against the DUT.
// Output vector bits: {PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset,
// csr_WE, int_taken, mret_exec, illegal_o(0 when not built)}.
// ----------------------------------------------------------------------------
module tb_otter_cu_fsm_mc;

    localparam int B_P = 9, B_R = 8, B_W = 7, B_I1 = 6, B_D2 = 5;
    localparam int B_RS = 4, B_C = 3, B_T = 2, B_M = 1, B_IL = 0;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011, SYS = 7'b1110011;
    localparam logic [6:0] RTYPE = 7'b0110011, ITYPE = 7'b0010011;
    localparam logic [6:0] JALR = 7'b1100111, JAL = 7'b1101111;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;

    typedef struct {
        logic [2:0] s;
        logic [9:0] o;
        string      tag;
    } exp_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst    [2];
    logic [6:0] op     [2];
    logic [2:0] f3     [2];
    logic       intr_i [2];
    logic       mie_i  [2];
    logic [9:0] outv   [2];
    logic [2:0] st     [2];

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic pcw, rw, we2, rd1, rd2, rs, cwe, it, mx, ill;
        logic [2:0] so;
        otter_cu_fsm_mc #(
            .IMEM_LAT(g == 0 ? 3 : 1),
            .DMEM_LAT(g == 0 ? 2 : 1)
        ) dut (
            .CLK(CLK), .RST(rst[g]), .ir_opcode(op[g]), .ir_funct3(f3[g]),
            .intr(intr_i[g]), .mie(mie_i[g]),
            .PCWrite(pcw), .regWrite(rw), .memWE2(we2), .memRDEN1(rd1),
            .memRDEN2(rd2), .reset(rs), .csr_WE(cwe), .int_taken(it),
            .mret_exec(mx), .state_o(so)
`ifdef CU_ILLEGAL_TRAP_EN
            , .illegal_o(ill)
`endif
        );
`ifndef CU_ILLEGAL_TRAP_EN
        assign ill = 1'b0;
`endif
        assign outv[g] = {pcw, rw, we2, rd1, rd2, rs, cwe, it, mx, ill};
        assign st[g]   = so;
    end

    function automatic int unsigned imem_of(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic int unsigned dmem_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic logic known_op(input logic [6:0] o);
        return o inside {LOAD, STORE, BRANCH, SYS, RTYPE, ITYPE, JALR, JAL, LUI, AUIPC};
    endfunction

    function automatic logic trap_op(input logic [6:0] o);
`ifdef CU_ILLEGAL_TRAP_EN
        return !known_op(o);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [9:0] bit1(input int b);
        logic [9:0] v;
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    // Outputs of the execute cycle of an instruction.
    function automatic logic [9:0] exec_vec(input logic [6:0] o, input logic [2:0] fn);
        if (o == LOAD) return bit1(B_D2);
        if (o inside {RTYPE, ITYPE, JALR, JAL, LUI, AUIPC}) return bit1(B_P) | bit1(B_R);
        if (o == STORE) return bit1(B_P) | bit1(B_W);
        if (o == SYS) begin
            if (fn == 3'b000) return bit1(B_P) | bit1(B_M);
            if (fn == 3'b100) return bit1(B_P);
            return bit1(B_P) | bit1(B_R) | bit1(B_C);
        end
        if (trap_op(o)) return bit1(B_P) | bit1(B_IL);
        return bit1(B_P);
    endfunction

    function automatic void push(input int d, input logic [2:0] s, input logic [9:0] o,
                                 input string tag);
        exp_t e;
        e.s   = s;
        e.o   = o;
        e.tag = tag;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Queue this cycle's expectation, then advance to just after the next edge.
    task automatic cyc(input int d, input logic [2:0] s, input logic [9:0] o, input string tag);
        push(d, s, o, tag);
        @(posedge CLK);
        #1;
    endtask

    // mode 0: random intr/mie, 1: intr=mie=1 throughout, 2: intr=1 mie=0 throughout
    task automatic set_irq(input int d, input int mode, output logic take);
        case (mode)
            1:       begin intr_i[d] = 1'b1; mie_i[d] = 1'b1; end
            2:       begin intr_i[d] = 1'b1; mie_i[d] = 1'b0; end
            default: begin
                intr_i[d] = ($urandom_range(0, 2) == 0);
                mie_i[d]  = $urandom_range(0, 1) == 1;
            end
        endcase
        take = intr_i[d] && mie_i[d];
    endtask

    task automatic run_instr(input int d, input logic [6:0] o, input logic [2:0] fn,
                             input int mode, output int ncyc);
        int unsigned il, dl;
        logic        take;
        il      = imem_of(d);
        dl      = dmem_of(d);
        ncyc    = 0;
        op[d]   = o;
        f3[d]   = fn;
        for (int unsigned i = 0; i < il; i++) begin
            set_irq(d, mode, take);
            cyc(d, 3'd1, bit1(B_I1), "fetch");
            ncyc++;
        end
        set_irq(d, mode, take);
        cyc(d, 3'd2, exec_vec(o, fn), "exec");
        ncyc++;
        if (o == LOAD) begin
            for (int unsigned i = 1; i < dl; i++) begin
                set_irq(d, mode, take);
                cyc(d, 3'd3, bit1(B_D2), "ldwait");
                ncyc++;
            end
            set_irq(d, mode, take);
            cyc(d, 3'd4, bit1(B_P) | bit1(B_R), "wb");
            ncyc++;
        end else if (trap_op(o)) begin
            take = 1'b1;
        end
        if (take) begin
            intr_i[d] = 1'b0;
            cyc(d, 3'd5, bit1(B_P) | bit1(B_T), "intr");
        end
    endtask

    task automatic run_dut(input int d);
        int         n;
        logic [6:0] ops[10];
        logic [6:0] o;
        int         k;
        ops = '{LOAD, STORE, BRANCH, SYS, RTYPE, ITYPE, JALR, JAL, LUI, AUIPC};
        rst[d]    = 1'b1;
        op[d]     = '0;
        f3[d]     = '0;
        intr_i[d] = 1'b0;
        mie_i[d]  = 1'b0;
        @(posedge CLK);
        #1;
        cyc(d, 3'd0, bit1(B_RS), "rst_hold");
        rst[d] = 1'b0;
        cyc(d, 3'd0, bit1(B_RS), "init");

        run_instr(d, RTYPE, 3'b000, 2, n);
        pin($sformatf("add_latency_dut%0d", d), n, imem_of(d) + 1);
        run_instr(d, LOAD, 3'b010, 2, n);
        pin($sformatf("load_latency_dut%0d", d), n, imem_of(d) + dmem_of(d) + 1);
        run_instr(d, STORE, 3'b010, 1, n);
        run_instr(d, STORE, 3'b010, 2, n);
        run_instr(d, SYS, 3'b000, 1, n);
        run_instr(d, SYS, 3'b001, 2, n);
        run_instr(d, SYS, 3'b100, 2, n);
        run_instr(d, 7'b1111111, 3'b000, 2, n);
        run_instr(d, LOAD, 3'b000, 1, n);
        run_instr(d, BRANCH, 3'b000, 0, n);

        if (dmem_of(d) > 1) begin
            op[d] = LOAD;
            intr_i[d] = 1'b0;
            for (int unsigned i = 0; i < imem_of(d); i++) cyc(d, 3'd1, bit1(B_I1), "fetch");
            cyc(d, 3'd2, bit1(B_D2), "exec");
            rst[d] = 1'b1;
            cyc(d, 3'd3, bit1(B_D2), "ldwait_rst");
            rst[d] = 1'b0;
            cyc(d, 3'd0, bit1(B_RS), "init_after_rst");
        end

        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 10);
            if (k == 10) o = 7'($urandom);
            else         o = ops[k];
            run_instr(d, o, 3'($urandom_range(0, 7)), 0, n);
        end
    endtask

    always @(negedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            logic have;
            have = 1'b0;
            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (have) begin
                total++;
                if (outv[d] !== e.o || st[d] !== e.s) begin
                    bad++;
                    $display("FAIL dut%0d %s @%0t: got out=%b st=%0d want out=%b st=%0d",
                             d, e.tag, $time, outv[d], st[d], e.o, e.s);
                end
            end
        end
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL timeout: run did not complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        pin("model_add",   exec_vec(RTYPE, 3'b000), 32'b1100000000);
        pin("model_load",  exec_vec(LOAD, 3'b010),  32'b0000100000);
        pin("model_store", exec_vec(STORE, 3'b010), 32'b1010000000);
        pin("model_mret",  exec_vec(SYS, 3'b000),   32'b1000000010);
        pin("model_csrrw", exec_vec(SYS, 3'b001),   32'b1100001000);
        pin("model_sys4",  exec_vec(SYS, 3'b100),   32'b1000000000);
`ifdef CU_ILLEGAL_TRAP_EN
        pin("model_undef", exec_vec(7'b1111111, 3'b000), 32'b1000000001);
`else
        pin("model_undef", exec_vec(7'b1111111, 3'b000), 32'b1000000000);
`endif
        fork
            run_dut(0);
            run_dut(1);
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
